// File: rtl/lvds_tx_framer.sv
// I/Q frame serializer: pops 32-bit words from a FWFT FIFO and emits 16-dibit frames
// (sync 10, 7 I dibits, sync 01, 7 Q dibits). Optional test pattern source: LVDS_TX_TEST_PATTERN_EN.
module lvds_tx_framer #(
  parameter logic [1:0] IDLE_DIBIT = 2'b00,
  parameter int         UCNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic [31:0]       i_fifo_data,
  output logic              o_fifo_pull,
  output logic [1:0]        o_tx_data,
  output logic              o_tx_frame,
  output logic [UCNT_W-1:0] o_underrun_cnt,
  output logic [1:0]        o_debug_state
`ifdef LVDS_TX_TEST_PATTERN_EN
  ,
  input  logic              i_test_mode
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_I_PH = 2'b01,
    S_Q_PH = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [27:0]       r_shift;
  logic              r_armed;
  logic [UCNT_W-1:0] r_ucnt;

  logic              w_test;
  logic              w_word_avail;
  logic [27:0]       w_word;
  logic              w_frame_end;
  logic              w_load;
  logic              w_underrun;
  logic              w_unused_bits;

`ifdef LVDS_TX_TEST_PATTERN_EN
  logic [13:0] r_pat;

  assign w_test       = i_test_mode;
  assign w_word_avail = i_test_mode | ~i_fifo_empty;
  assign w_word       = i_test_mode ? {r_pat, ~r_pat}
                                    : {i_fifo_data[29:16], i_fifo_data[13:0]};

  // Pattern advances once per frame it sources; 14-bit natural wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_pat <= '0;
    else if (w_load && i_test_mode)
      r_pat <= r_pat + 14'd1;
  end
`else
  assign w_test       = 1'b0;
  assign w_word_avail = ~i_fifo_empty;
  assign w_word       = {i_fifo_data[29:16], i_fifo_data[13:0]};
`endif

  assign w_unused_bits = ^{i_fifo_data[31:30], i_fifo_data[15:14]};

  assign w_frame_end = (r_state == S_Q_PH) && (r_idx == 4'd15);
  assign w_load      = i_enable && w_word_avail && ((r_state == S_IDLE) || w_frame_end);
  assign o_fifo_pull = w_load && !i_reset && !w_test;

  // An empty FIFO only counts once a stream has started (armed) or when a frame just ended.
  assign w_underrun  = !w_test && i_enable && i_fifo_empty &&
                       (w_frame_end || ((r_state == S_IDLE) && r_armed));

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_shift    <= '0;
      r_armed    <= 1'b0;
      r_ucnt     <= '0;
      o_tx_data  <= IDLE_DIBIT;
      o_tx_frame <= 1'b0;
    end else begin
      if (!i_enable)
        r_armed <= 1'b0;
      else if (w_load)
        r_armed <= 1'b1;

      if (w_underrun && (r_ucnt != {UCNT_W{1'b1}}))
        r_ucnt <= r_ucnt + 1'b1;

      if (w_load) begin
        r_shift    <= w_word;
        r_state    <= S_I_PH;
        r_idx      <= 4'd0;
        o_tx_data  <= SYNC_I;
        o_tx_frame <= 1'b1;
      end else begin
        case (r_state)
          S_I_PH: begin
            r_idx      <= r_idx + 4'd1;
            o_tx_frame <= 1'b1;
            if (r_idx == 4'd7) begin
              // After seven shifts the Q field already sits at the top of r_shift.
              r_state   <= S_Q_PH;
              o_tx_data <= SYNC_Q;
            end else begin
              o_tx_data <= r_shift[27:26];
              r_shift   <= {r_shift[25:0], 2'b00};
            end
          end
          S_Q_PH: begin
            if (r_idx == 4'd15) begin
              r_state    <= S_IDLE;
              r_idx      <= 4'd0;
              o_tx_data  <= IDLE_DIBIT;
              o_tx_frame <= 1'b0;
            end else begin
              r_idx      <= r_idx + 4'd1;
              o_tx_data  <= r_shift[27:26];
              r_shift    <= {r_shift[25:0], 2'b00};
              o_tx_frame <= 1'b1;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            o_tx_data  <= IDLE_DIBIT;
            o_tx_frame <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_underrun_cnt = r_ucnt;
  assign o_debug_state  = r_state;

endmodule
